// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, field and state definitions shared by the decode controller
package cpu_pkg;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_MVHI = 4'd6;
    localparam logic [3:0] OP_J    = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_JN   = 4'd10;
    localparam logic [3:0] OP_CALL = 4'd12;

    localparam int OPC_LSB = 0;
    localparam int IMM_BIT = 4;
    localparam int RX_LSB  = 5;
    localparam int RY_LSB  = 8;

    // All-zero word is the injected bubble; it must never look like "mv r0,r0".
    localparam logic [15:0] NOP      = 16'h0000;
    localparam logic [2:0]  LINK_REG = 3'd7;

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_t;
    typedef enum logic [1:0] {PC_INC = 2'd0, PC_REL = 2'd1, PC_REG = 2'd2} pc_sel_t;
    typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_EX = 2'd1, FWD_WR = 2'd2} fwd_sel_t;

    function automatic logic is_valid(input logic [15:0] ir);
        return ir != NOP;
    endfunction

    function automatic logic is_writer(input logic valid, input logic [3:0] op);
        return valid && (op == OP_MV || op == OP_ADD || op == OP_SUB ||
                         op == OP_MVHI || op == OP_LD || op == OP_CALL);
    endfunction

    function automatic logic [2:0] dest_reg(input logic [3:0] op, input logic [2:0] rx);
        return (op == OP_CALL) ? LINK_REG : rx;
    endfunction

    function automatic logic is_flag_setter(input logic valid, input logic [3:0] op);
        return valid && (op == OP_ADD || op == OP_SUB || op == OP_CMP);
    endfunction

    function automatic logic is_jump(input logic [3:0] op);
        return op == OP_J || op == OP_JZ || op == OP_JN || op == OP_CALL;
    endfunction

    // Register-form jumps read Rx as the target; immediate forms reuse those bits for imm11.
    function automatic logic reads_x(input logic valid, input logic [3:0] op, input logic imm);
        return valid && (op == OP_ADD || op == OP_SUB || op == OP_CMP || op == OP_ST ||
                         op == OP_MVHI || (is_jump(op) && !imm));
    endfunction

    function automatic logic reads_y(input logic valid, input logic [3:0] op, input logic imm);
        return valid && !imm && (op == OP_MV || op == OP_ADD || op == OP_SUB ||
                                 op == OP_CMP || op == OP_LD || op == OP_ST);
    endfunction

endpackage

// File: rtl/cpu_decode_control_if.sv
// rtl/cpu_decode_control_if.sv - pipeline-side signal bundle of the decode controller
interface cpu_decode_control_if;
    logic [15:0] i_ir_dc;
    logic [15:0] i_ir_ex;
    logic [15:0] i_ir_wr;
    logic        i_alu_n;
    logic        i_alu_z;
    logic        i_alu_n_imm;
    logic        i_alu_z_imm;
    logic        o_pc_rd;
    logic        o_pc_ld;
    logic        o_pc_dc_ld;
    logic        o_pc_ex_ld;
    logic [1:0]  o_pc_sel;
    logic        o_ir_ex_ld;
    logic        o_ir_ex_sel;
    logic        o_rf_datax_ld;
    logic        o_rf_datay_ld;
    logic [1:0]  o_fwd_x_sel;
    logic [1:0]  o_fwd_y_sel;
    logic        o_stall;
    logic        o_flush;

    modport master (
        output i_ir_dc, i_ir_ex, i_ir_wr, i_alu_n, i_alu_z, i_alu_n_imm, i_alu_z_imm,
        input  o_pc_rd, o_pc_ld, o_pc_dc_ld, o_pc_ex_ld, o_pc_sel, o_ir_ex_ld, o_ir_ex_sel,
               o_rf_datax_ld, o_rf_datay_ld, o_fwd_x_sel, o_fwd_y_sel, o_stall, o_flush
    );

    modport slave (
        input  i_ir_dc, i_ir_ex, i_ir_wr, i_alu_n, i_alu_z, i_alu_n_imm, i_alu_z_imm,
        output o_pc_rd, o_pc_ld, o_pc_dc_ld, o_pc_ex_ld, o_pc_sel, o_ir_ex_ld, o_ir_ex_sel,
               o_rf_datax_ld, o_rf_datay_ld, o_fwd_x_sel, o_fwd_y_sel, o_stall, o_flush
    );
endinterface

// File: rtl/cpu_hazard_unit.sv
// rtl/cpu_hazard_unit.sv - writer/source register matching for forwarding and load-use detection
module cpu_hazard_unit
    import cpu_pkg::*;
(
    input  logic [15:0] ir_dc,
    input  logic [15:0] ir_ex,
    input  logic [15:0] ir_wr,
    output fwd_sel_t    fwd_x_sel,
    output fwd_sel_t    fwd_y_sel,
    output logic        load_use
);

    logic [3:0] dc_op, ex_op, wr_op;
    logic [2:0] dc_rx, dc_ry, ex_dst, wr_dst;
    logic       dc_imm, dc_rd_x, dc_rd_y, ex_wr, wr_wr;

    assign dc_op  = ir_dc[OPC_LSB +: 4];
    assign ex_op  = ir_ex[OPC_LSB +: 4];
    assign wr_op  = ir_wr[OPC_LSB +: 4];
    assign dc_imm = ir_dc[IMM_BIT];
    assign dc_rx  = ir_dc[RX_LSB +: 3];
    assign dc_ry  = ir_dc[RY_LSB +: 3];

    assign dc_rd_x = reads_x(is_valid(ir_dc), dc_op, dc_imm);
    assign dc_rd_y = reads_y(is_valid(ir_dc), dc_op, dc_imm);
    assign ex_wr   = is_writer(is_valid(ir_ex), ex_op);
    assign wr_wr   = is_writer(is_valid(ir_wr), wr_op);
    assign ex_dst  = dest_reg(ex_op, ir_ex[RX_LSB +: 3]);
    assign wr_dst  = dest_reg(wr_op, ir_wr[RX_LSB +: 3]);

    // EX holds the younger value, so it wins over WR when both write the same register.
    always_comb begin
        fwd_x_sel = FWD_RF;
        fwd_y_sel = FWD_RF;
        if (dc_rd_x && ex_wr && ex_dst == dc_rx)
            fwd_x_sel = FWD_EX;
        else if (dc_rd_x && wr_wr && wr_dst == dc_rx)
            fwd_x_sel = FWD_WR;
        if (dc_rd_y && ex_wr && ex_dst == dc_ry)
            fwd_y_sel = FWD_EX;
        else if (dc_rd_y && wr_wr && wr_dst == dc_ry)
            fwd_y_sel = FWD_WR;
    end

    assign load_use = ex_wr && ex_op == OP_LD &&
                      ((dc_rd_x && dc_rx == ex_dst) || (dc_rd_y && dc_ry == ex_dst));

endmodule

// File: rtl/cpu_decode_control.sv
// rtl/cpu_decode_control.sv - decode-stage control: fetch/PC steering, forwarding, stall and flush
module cpu_decode_control
    import cpu_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    cpu_decode_control_if.slave  bus
);

    state_t     state;
    fwd_sel_t   fwd_x_sel, fwd_y_sel;
    logic       load_use;
    logic       ex_flag_setter, flag_z, flag_n, taken;
    logic [3:0] dc_op;

    cpu_hazard_unit u_hazard (
        .ir_dc     (bus.i_ir_dc),
        .ir_ex     (bus.i_ir_ex),
        .ir_wr     (bus.i_ir_wr),
        .fwd_x_sel (fwd_x_sel),
        .fwd_y_sel (fwd_y_sel),
        .load_use  (load_use)
    );

    assign dc_op = bus.i_ir_dc[OPC_LSB +: 4];

    // A flag setter in EX has not committed yet, so its flags bypass the committed copy.
    assign ex_flag_setter = is_flag_setter(is_valid(bus.i_ir_ex), bus.i_ir_ex[OPC_LSB +: 4]);
    assign flag_z = ex_flag_setter ? bus.i_alu_z_imm : bus.i_alu_z;
    assign flag_n = ex_flag_setter ? bus.i_alu_n_imm : bus.i_alu_n;

    always_comb begin
        taken = 1'b0;
        case (dc_op)
            OP_J, OP_CALL: taken = 1'b1;
            OP_JZ:         taken = flag_z;
            OP_JN:         taken = flag_n;
            default:       taken = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_BOOT;
        end else begin
            case (state)
                ST_BOOT:  state <= ST_RUN;
                ST_RUN:   state <= (!load_use && taken) ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_BOOT;
            endcase
        end
    end

    always_comb begin
        bus.o_pc_rd       = 1'b0;
        bus.o_pc_ld       = 1'b0;
        bus.o_pc_dc_ld    = 1'b0;
        bus.o_pc_ex_ld    = 1'b0;
        bus.o_pc_sel      = PC_INC;
        bus.o_ir_ex_ld    = 1'b0;
        bus.o_ir_ex_sel   = 1'b1;
        bus.o_rf_datax_ld = 1'b0;
        bus.o_rf_datay_ld = 1'b0;
        bus.o_fwd_x_sel   = FWD_RF;
        bus.o_fwd_y_sel   = FWD_RF;
        bus.o_stall       = 1'b0;
        bus.o_flush       = 1'b0;
        if (!i_reset) begin
            case (state)
                ST_BOOT: begin
                    bus.o_pc_rd    = 1'b1;
                    bus.o_pc_ld    = 1'b1;
                    bus.o_ir_ex_ld = 1'b1;
                end
                ST_RUN: begin
                    bus.o_pc_rd       = 1'b1;
                    bus.o_pc_ld       = 1'b1;
                    bus.o_pc_dc_ld    = 1'b1;
                    bus.o_pc_ex_ld    = 1'b1;
                    bus.o_ir_ex_ld    = 1'b1;
                    bus.o_ir_ex_sel   = 1'b0;
                    bus.o_rf_datax_ld = 1'b1;
                    bus.o_rf_datay_ld = 1'b1;
                    bus.o_fwd_x_sel   = fwd_x_sel;
                    bus.o_fwd_y_sel   = fwd_y_sel;
                    // A stalled DC is re-presented next cycle, so its branch waits until then.
                    if (load_use) begin
                        bus.o_stall     = 1'b1;
                        bus.o_pc_rd     = 1'b0;
                        bus.o_pc_ld     = 1'b0;
                        bus.o_pc_dc_ld  = 1'b0;
                        bus.o_ir_ex_sel = 1'b1;
                    end else if (taken) begin
                        bus.o_pc_sel = bus.i_ir_dc[IMM_BIT] ? PC_REL : PC_REG;
                    end
                end
                ST_FLUSH: begin
                    bus.o_pc_rd       = 1'b1;
                    bus.o_pc_ld       = 1'b1;
                    bus.o_pc_dc_ld    = 1'b1;
                    bus.o_pc_ex_ld    = 1'b1;
                    bus.o_ir_ex_ld    = 1'b1;
                    bus.o_rf_datax_ld = 1'b1;
                    bus.o_rf_datay_ld = 1'b1;
                    bus.o_flush       = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
